// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared instruction-cache definitions: line geometry, the
//               refill controller state type and the cache line type.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_BYTES  = LINE_WORDS * DATA_WIDTH / 8;
  localparam int OFFSET_BITS = 4;
  localparam int LINE_BITS   = LINE_WORDS * DATA_WIDTH;
  localparam int LADDR_BITS  = 32 - OFFSET_BITS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } refill_state_t;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [1:0]           beat_t;

endpackage
`default_nettype wire

// File: rtl/inst_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_refill_ctrl_if
// Description : Instruction-memory read port, one word per request/response
//               transaction.
//   req    : read request, held until granted
//   addr   : word-aligned request address
//   gnt    : request accepted this cycle
//   rvalid : read data valid (one per grant, at least one cycle after it)
//   rdata  : read data
// Modports    : master (refill controller), slave (memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_refill_ctrl_if;
  import icache_pkg::*;

  logic                  req;
  logic [31:0]           addr;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface
`default_nettype wire

// File: rtl/refill_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : refill_line_buf
// Description : 4 x 32-bit line assembly buffer, written by beat index.
//   clk, rst_n : clock, synchronous active-low reset (clears all words)
//   i_we       : write strobe
//   i_idx      : word slot to write
//   i_wdata    : word to write
//   o_line     : assembled line, word i at bits [32i+31:32i]
// Revision    : 1.0 - initial release
// ============================================================================
module refill_line_buf
  import icache_pkg::*;
(
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  i_we,
  input  wire [1:0]            i_idx,
  input  wire [DATA_WIDTH-1:0] i_wdata,
  output line_t                o_line
);

  logic [DATA_WIDTH-1:0] r_word [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++) r_word[i] <= '0;
    end else if (i_we) begin
      r_word[i_idx] <= i_wdata;
    end
  end

  always_comb begin
    o_line = '0;
    for (int i = 0; i < LINE_WORDS; i++) o_line[i*DATA_WIDTH +: DATA_WIDTH] = r_word[i];
  end

endmodule
`default_nettype wire

// File: rtl/inst_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_refill_ctrl
// Description : Instruction-cache refill controller. On a miss, fetches the
//               16-byte line from memory one word at a time, assembles it and
//               presents it to the cache with a one-cycle fill strobe.
//   clk, rst_n     : clock, synchronous active-low reset
//   i_miss         : cache miss, sampled in IDLE
//   i_miss_addr    : fetch address of the miss
//   i_flush        : pipeline redirect, aborts the refill
//   mem            : memory read port (master side)
//   o_fetch_data   : assembled 128-bit line
//   o_fetch_enable : one-cycle fill strobe
//   o_refill_busy  : high whenever not IDLE (stalls the PC)
// Option      : ICACHE_CWF_EN - critical-word-first; start at miss_addr[3:2]
// Revision    : 1.0 - initial release
// ============================================================================
module inst_refill_ctrl
  import icache_pkg::*;
(
  input  wire                       clk,
  input  wire                       rst_n,
  input  wire                       i_miss,
  input  wire [31:0]                i_miss_addr,
  input  wire                       i_flush,
  inst_refill_ctrl_if.master        mem,
  output line_t                     o_fetch_data,
  output logic                      o_fetch_enable,
  output logic                      o_refill_busy
);

  refill_state_t         r_state, w_state_nxt;
  logic [LADDR_BITS-1:0] r_line,  w_line_nxt;
  beat_t                 r_beat,  w_beat_nxt;
  beat_t                 r_cnt,   w_cnt_nxt;     // beats already received
  beat_t                 w_start_beat;
  logic                  w_buf_we;
  logic                  r_mem_req;
  logic [31:0]           r_mem_addr;
  logic                  w_unused_addr_bits;

`ifdef ICACHE_CWF_EN
  assign w_start_beat = i_miss_addr[3:2];
`else
  assign w_start_beat = 2'd0;
`endif

  // Offset bits do not all feed logic in every build.
  assign w_unused_addr_bits = &{1'b0, i_miss_addr[3:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line;
    w_beat_nxt  = r_beat;
    w_cnt_nxt   = r_cnt;
    w_buf_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_miss && !i_flush) begin
          w_state_nxt = ST_REQ;
          w_line_nxt  = i_miss_addr[31:OFFSET_BITS];
          w_beat_nxt  = w_start_beat;
          w_cnt_nxt   = 2'd0;
        end
      end
      ST_REQ: begin
        // A granted request must have its response drained before IDLE.
        if (i_flush)      w_state_nxt = mem.gnt ? ST_DRAIN : ST_IDLE;
        else if (mem.gnt) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_flush) begin
          w_state_nxt = mem.rvalid ? ST_IDLE : ST_DRAIN;
        end else if (mem.rvalid) begin
          w_buf_we = 1'b1;
          if (r_cnt == 2'd3) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_REQ;
            w_beat_nxt  = r_beat + 2'd1;
            w_cnt_nxt   = r_cnt + 2'd1;
          end
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_DRAIN: if (mem.rvalid) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_line     <= '0;
      r_beat     <= 2'd0;
      r_cnt      <= 2'd0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_line    <= w_line_nxt;
      r_beat    <= w_beat_nxt;
      r_cnt     <= w_cnt_nxt;
      // Request is registered from the next state so it is high exactly
      // while the FSM sits in REQ; the address only moves on REQ entry.
      r_mem_req <= (w_state_nxt == ST_REQ);
      if (w_state_nxt == ST_REQ) r_mem_addr <= {w_line_nxt, w_beat_nxt, 2'b00};
    end
  end

  refill_line_buf u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_buf_we),
    .i_idx   (r_beat),
    .i_wdata (mem.rdata),
    .o_line  (o_fetch_data)
  );

  assign mem.req        = r_mem_req;
  assign mem.addr       = r_mem_addr;
  assign o_fetch_enable = (r_state == ST_DONE) && !i_flush;
  assign o_refill_busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/inst_refill_ctrl.md
# inst_refill_ctrl

Instruction-cache refill controller sitting directly upstream of the instruction cache. On a cache miss it fetches the 4-word (16-byte) line containing the miss address from instruction memory, one word per request/response transaction, and assembles it. It then presents the line to the cache as a 128-bit block with a one-cycle fill strobe. It also drives a busy flag the fetch stage uses to stall the PC while a refill is in flight.

## Interface
- DATA_WIDTH, 32, word width
- LINE_WORDS, 4, words per cache line (fixed at 4; beat counter is 2 bits)
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- miss  in  1  cache miss (inverse of cache hit), sampled in IDLE
- miss_addr  in  32  fetch address of the miss
- flush  in  1  pipeline redirect; abort refill
- mem_req  out  1  memory read request, held until granted
- mem_addr  out  32  word-aligned request address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid (exactly one per grant, ≥1 cycle after grant)
- mem_rdata  in  32  read data
- fetch_data  out  128  assembled line, word i at bits [32i+31:32i]
- fetch_enable  out  1  one-cycle fill strobe to the cache
- refill_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: miss=1 and flush=0 → latch line address miss_addr[31:4], set beat = start beat, go to REQ.
- REQ: mem_req=1, mem_addr={line,beat,2'b00}. mem_gnt=1 → WAIT.
- WAIT: on mem_rvalid, write mem_rdata into word slot [beat] of fetch_data.
  - If this was the 4th beat → DONE.
  - Otherwise beat = beat+1 (mod 4) → REQ.
- DONE: fetch_enable = (state==DONE) && !flush, then → IDLE. This is the only combinational output term.
- Flush handling:
  - IDLE: flush has no effect.
  - REQ without gnt: → IDLE; no request is left outstanding.
  - REQ with gnt the same cycle: → DRAIN.
  - WAIT without rvalid: → DRAIN.
  - WAIT with rvalid the same cycle: → IDLE.
  - DRAIN: discard the next rvalid, then → IDLE. Flush has no further effect while in DRAIN.
  - DONE: strobe is suppressed; → IDLE.
- fetch_data holds its contents after DONE until the next refill overwrites it.
- A new miss is never accepted outside IDLE.

## Timing
- Reset values (synchronous, rst_n=0 at a clk edge): state IDLE, beat 0, mem_req 0, mem_addr 0, fetch_data 0, fetch_enable 0, refill_busy 0.
- Reset mid-refill returns to IDLE the next cycle. Any memory response still in flight is ignored.
- mem_req and mem_addr are registered. mem_req rises the cycle after the miss is seen in IDLE.
- Minimum latency (gnt on the first REQ cycle, rvalid the cycle after gnt): 2 cycles per beat.
  - Miss seen at cycle 0; DONE at cycle 9; fetch_enable high in cycle 9; IDLE at cycle 10.
- Each extra gnt-wait or rvalid-wait cycle adds exactly one cycle of latency.
- mem_addr is stable for the whole time mem_req is high.

## Configuration
- ICACHE_CWF_EN, critical-word-first.
  - Defined: start beat = miss_addr[3:2]; beats wrap modulo 4. Example: start beat 2 gives order 2,3,0,1.
  - Undefined: start beat = 0; beats are always requested in order 0,1,2,3.
- Total latency is identical in both modes. Only the request order changes.

## Structure
- Shared package icache_pkg holds:
  - LINE_WORDS, LINE_BYTES, OFFSET_BITS = 4;
  - typedef refill_state_t (the 5-state enum);
  - typedef line_t (logic [127:0]).
- The instruction cache imports icache_pkg for its line width.
- One sub-module, refill_line_buf: 4×32 register file written by beat index on rvalid, cleared on reset, drives fetch_data.
- The FSM and beat counter stay in inst_refill_ctrl.

## Test plan
- Miss to 0x0000_0104, gnt immediate, rvalid +1 cycle, data 0xA0..0xA3:
  - mem_addr sequence is 0x100,0x104,0x108,0x10C (CWF off) or 0x104,0x108,0x10C,0x100 (CWF on);
  - fetch_data = {0xA3,0xA2,0xA1,0xA0};
  - fetch_enable high exactly in cycle 9.
- Grant withheld 3 cycles on beat 1: mem_req and mem_addr 0x104 held steady; fetch_enable arrives at cycle 12.
- Flush in REQ with gnt=0: → IDLE next cycle, mem_req low, no fetch_enable.
- Flush in WAIT without rvalid, rvalid 2 cycles later: enters DRAIN, rvalid data discarded, back in IDLE, refill_busy low, no fetch_enable.
- Flush coincident with DONE: fetch_enable stays 0.
- rst_n low during beat 2: all outputs return to reset values the next cycle; a new miss afterwards refills correctly.
